// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, returns cos/sin of a
// fixed-point angle behind valid/ready handshakes on both sides.
module cordic_rotator #(
    parameter int INTS  = 1,
    parameter int FRACS = 21,
    parameter int WIDTH = INTS + FRACS + 1,
    parameter int ITER  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIDTH:0] theta,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH:0] cos_out,
    output logic [WIDTH:0] sin_out,
    output logic           range_err
);

    localparam int ZW = WIDTH + 3;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef logic signed [ZW-1:0] word_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // atan(1/n) scaled by 2^60, alternating Taylor series in pure integer arithmetic
    function automatic longint atan_recip(input longint n);
        longint p;
        longint acc;
        p   = (longint'(1) <<< 60) / n;
        acc = 0;
        for (int unsigned k = 0; k < 40; k++) begin
            if (k[0])
                acc = acc - p / longint'(2 * k + 1);
            else
                acc = acc + p / longint'(2 * k + 1);
            p = p / n / n;
        end
        return acc;
    endfunction

    // atan(1) = atan(1/2) + atan(1/3) keeps the series convergent for entry 0
    function automatic word_t atan_fx(input int unsigned i);
        longint v;
        if (i == 0)
            v = atan_recip(2) + atan_recip(3);
        else
            v = atan_recip(longint'(1) <<< i);
        return word_t'((v + (longint'(1) <<< (59 - FRACS))) >>> (60 - FRACS));
    endfunction

    function automatic logic [ITER*ZW-1:0] build_atan_table();
        logic [ITER*ZW-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < ITER; i++)
            t = t | ((ITER * ZW)'(unsigned'(atan_fx(i))) << (i * ZW));
        return t;
    endfunction

    localparam logic [ITER*ZW-1:0] ATAN_TABLE = build_atan_table();
    localparam word_t K_FX       = word_t'($rtoi(0.6072529350088813 * (2.0 ** FRACS) + 0.5));
    localparam word_t HALF_PI_FX = word_t'($rtoi(1.5707963 * (2.0 ** FRACS) + 0.5));
    localparam word_t SAT_MAX    = {3'b000, {WIDTH{1'b1}}};
    localparam word_t SAT_MIN    = {3'b111, {WIDTH{1'b0}}};

    function automatic logic [WIDTH:0] sat(input word_t v);
        if (v > SAT_MAX)
            return SAT_MAX[WIDTH:0];
        else if (v < SAT_MIN)
            return SAT_MIN[WIDTH:0];
        else
            return v[WIDTH:0];
    endfunction

    state_t         state_q, state_d;
    word_t          x_q, x_d, y_q, y_d, z_q, z_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [WIDTH:0] cos_q, cos_d, sin_q, sin_d;
    logic           range_err_q, range_err_d;

    word_t theta_ext, theta_abs;
    word_t x_sh, y_sh, atan_cur;

    assign theta_ext = {{2{theta[WIDTH]}}, theta};
    assign theta_abs = theta_ext[ZW-1] ? -theta_ext : theta_ext;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        range_err_d = range_err_q;
        x_sh        = x_q >>> cnt_q;
        y_sh        = y_q >>> cnt_q;
        atan_cur    = word_t'(ATAN_TABLE >> (cnt_q * ZW));

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    x_d         = K_FX;
                    y_d         = '0;
                    z_d         = theta_ext;
                    cnt_d       = '0;
                    range_err_d = (theta_abs > HALF_PI_FX);
                    in_ready_d  = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                in_ready_d = 1'b0;
                if (!z_q[ZW-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_cur;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_cur;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1))
                    state_d = DONE;
            end
            DONE: begin
                in_ready_d = 1'b0;
                // First DONE cycle captures the final x/y; the handshake only counts once valid is up
                if (!out_valid_q) begin
                    cos_d       = sat(x_q);
                    sin_d       = sat(y_q);
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cos_q       <= '0;
            sin_q       <= '0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            range_err_q <= range_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign cos_out   = cos_q;
    assign sin_out   = sin_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// Randomised self-checking bench for cordic_rotator: exact CORDIC reference built from
// real-valued atan/gain constants, plus a tolerance check against true cos/sin.
module tb_cordic_rotator;

    localparam int  FR   = 21;
    localparam int  NIT  = 16;
    localparam int  LAT  = NIT + 1;
    localparam real TOL  = 96.0;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] theta;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] cos_out;
    logic [23:0] sin_out;
    logic        range_err;

    int n_checks = 0;
    int n_fail   = 0;

    longint half_pi;

    cordic_rotator #(.INTS(1), .FRACS(FR), .ITER(NIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .theta    (theta),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cos_out  (cos_out),
        .sin_out  (sin_out),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    function automatic longint clamp24(input longint v);
        if (v > longint'(8388607)) return 8388607;
        if (v < -longint'(8388608)) return -8388608;
        return v;
    endfunction

    // Rotation-mode CORDIC with d chosen from the residual angle, on unbounded integers
    function automatic void model(input logic signed [23:0] th, output longint c,
                                  output longint s, output bit er);
        longint x, y, z, nx, ny, nz, at, a;
        x = longint'($rtoi(0.6072529350088813 * (2.0 ** FR) + 0.5));
        y = 0;
        z = longint'(th);
        for (int i = 0; i < NIT; i++) begin
            at = longint'($rtoi($atan(2.0 ** (-i)) * (2.0 ** FR) + 0.5));
            if (z >= 0) begin
                nx = x - (y >>> i); ny = y + (x >>> i); nz = z - at;
            end else begin
                nx = x + (y >>> i); ny = y - (x >>> i); nz = z + at;
            end
            x = nx; y = ny; z = nz;
        end
        c = clamp24(x);
        s = clamp24(y);
        a = (longint'(th) < 0) ? -longint'(th) : longint'(th);
        er = (a > half_pi);
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_ready: in_ready=%b after %0d cycles, required 1", in_ready, t);
        end
    endtask

    task automatic check_result(input string tag, input logic signed [23:0] th,
                                input longint ec, input longint es, input bit er);
        logic signed [23:0] exp_c, exp_s;
        real rc, rs, dc, ds;
        exp_c = 24'(ec);
        exp_s = 24'(es);
        n_checks++;
        if (cos_out !== exp_c) begin
            n_fail++;
            $display("FAIL %s cos theta=%0d: got %0d, required %0d", tag, th, $signed(cos_out), exp_c);
        end
        n_checks++;
        if (sin_out !== exp_s) begin
            n_fail++;
            $display("FAIL %s sin theta=%0d: got %0d, required %0d", tag, th, $signed(sin_out), exp_s);
        end
        n_checks++;
        if (range_err !== er) begin
            n_fail++;
            $display("FAIL %s range_err theta=%0d: got %b, required %b", tag, th, range_err, er);
        end
        if (!er) begin
            rc = $cos(real'(th) / (2.0 ** FR)) * (2.0 ** FR);
            rs = $sin(real'(th) / (2.0 ** FR)) * (2.0 ** FR);
            dc = real'($signed(cos_out)) - rc;
            ds = real'($signed(sin_out)) - rs;
            n_checks++;
            if (dc > TOL || dc < -TOL || ds > TOL || ds < -TOL) begin
                n_fail++;
                $display("FAIL %s accuracy theta=%0d: got cos=%0d sin=%0d, required near %0.1f %0.1f",
                         tag, th, $signed(cos_out), $signed(sin_out), rc, rs);
            end
        end
    endtask

    // Accept angle, wait for the result with a bounded budget; leaves caller #1 after the valid edge
    task automatic launch_and_wait(input string tag, input logic signed [23:0] th, output bit seen);
        int lat;
        wait_ready();
        theta    = th;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        theta    = 24'($urandom);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        n_checks++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL %s latency theta=%0d: got %0d cycles, required %0d", tag, th, lat, LAT);
        end
    endtask

    task automatic run_angle(input string tag, input logic signed [23:0] th);
        longint ec, es;
        bit er, seen;
        model(th, ec, es, er);
        out_ready = 1'b1;
        launch_and_wait(tag, th, seen);
        if (seen) begin
            check_result(tag, th, ec, es, er);
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s handshake: out_valid=%b in_ready=%b, required 0 1",
                         tag, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        theta = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || cos_out !== '0 ||
            sin_out !== '0 || range_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b cos=%h sin=%h rerr=%b, required all 0",
                     in_ready, out_valid, cos_out, sin_out, range_err);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_basic_angles();
        run_angle("zero", 24'sd0);
        run_angle("half_rad", 24'sd1048576);
        run_angle("neg_one_rad", -24'sd2097152);
    endtask

    task automatic test_range_err();
        logic signed [23:0] hp;
        hp = 24'(half_pi);
        run_angle("pi_half_edge", hp);
        run_angle("above_pi_half", hp + 24'sd1);
        run_angle("below_neg_pi_half", -hp - 24'sd1);
        run_angle("one_75_rad", 24'sd3670016);
        run_angle("most_negative", 24'sh800000);
    endtask

    task automatic test_random();
        logic signed [23:0] th;
        for (int i = 0; i < 12; i++) begin
            if (i < 6)
                th = 24'($signed({1'b0, $urandom_range(0, 6588396)}) - 3294198);
            else
                th = 24'($urandom);
            run_angle("random", th);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [23:0] th, other;
        longint ec, es;
        bit er, seen;
        logic signed [23:0] exp_c, exp_s;
        th    = 24'($signed({1'b0, $urandom_range(0, 3000000)}) - 1500000);
        other = 24'sd524288;
        model(th, ec, es, er);
        exp_c = 24'(ec);
        exp_s = 24'(es);
        out_ready = 1'b0;
        launch_and_wait("backpressure", th, seen);
        if (seen) begin
            @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (out_valid !== 1'b1 || cos_out !== exp_c || sin_out !== exp_s ||
                    range_err !== er || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold cycle %0d: valid=%b cos=%0d sin=%0d rerr=%b in_ready=%b, required 1 %0d %0d %b 0",
                             i, out_valid, $signed(cos_out), $signed(sin_out), range_err, in_ready,
                             exp_c, exp_s, er);
                end
                if (i == 3) begin
                    in_valid = 1'b1;
                    theta    = other;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
            end
        end
        run_angle("after_backpressure", other);
    endtask

    task automatic test_reset_mid_run();
        logic signed [23:0] th;
        th = 24'(half_pi + 5000);
        out_ready = 1'b1;
        wait_ready();
        theta    = th;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || cos_out !== '0 || sin_out !== '0 ||
            range_err !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b cos=%h sin=%h rerr=%b in_ready=%b, required all 0",
                     out_valid, cos_out, sin_out, range_err, in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        run_angle("after_reset", 24'sd0);
    endtask

    initial begin
        half_pi = longint'($rtoi(1.5707963 * (2.0 ** FR) + 0.5));
        test_reset();
        test_basic_angles();
        test_range_err();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
